ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers. It lives in the EX stage.
//  It consumes the rs/rt operands and the muldiv opcode from the ID/EX register.
//  HI/LO feed the EX-stage result mux for MFHI/MFLO, which is then latched by EX6_EX7.
//  It stalls the front of the pipeline while a MULT/DIV iterates.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  Clk          in   1      pipeline clock, rising edge
//  Reset        in   1      synchronous, active-high
//  MDOp_EX      in   3      0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//  rs_value_EX  in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//  rt_value_EX  in   WIDTH  multiplier / divisor
//  Stall        out  1      holds PC, IF/ID and ID/EX; combinational
//  Done         out  1      one-cycle pulse in FIN state
//  HI           out  WIDTH  HI register (registered)
//  LO           out  WIDTH  LO register (registered)
// BEHAVIOUR
//  Reset: state=IDLE; HI=LO=0; Stall=0; Done=0; counter and internal accumulators cleared.
//  States: IDLE, BUSY, FIN.
//  IDLE, MDOp 1-4:
//   - Latch |rs| and |rt|; signed ops use two's-complement abs, unsigned ops use the raw value.
//   - Latch the result signs and the op; counter=WIDTH; go to BUSY.
//  IDLE, MDOp 5/6: write HI/LO from rs at this edge; stay in IDLE; no stall.
//  IDLE, MDOp 0/7: HI/LO hold.
//  BUSY:
//   - One shift-add (mult) or restoring shift-subtract (div) step per cycle; counter--.
//   - When counter reaches 0: apply the sign fix, write HI/LO at this edge, go to FIN.
//  FIN: Done=1, Stall=0. MDOp is ignored, because the same instruction is still in EX. Next state is IDLE.
//  Stall = (state==BUSY) | (state==IDLE & MDOp in 1..4).
//   - Stall is high for exactly WIDTH+1 cycles: the issue cycle plus WIDTH BUSY cycles.
//   - The instruction leaves EX at the end of the FIN cycle.
//  Latency: new HI/LO are visible WIDTH+1 edges after the issue edge. MFHI in the next instruction sees the new value.
//  Multiply: the 2*WIDTH-bit unsigned product is negated when the sign flag is set; HI=upper half, LO=lower half.
//  Divide:
//   - LO=quotient, HI=remainder.
//   - Signed: quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
//   - Signed -2^(W-1) / -1: LO=0x80000000, HI=0. No exception.
//   - Divide by zero: LO=all ones, HI=rs, raw dividend. Full latency still applies.
//  Reset in BUSY or FIN: Reset wins. Go to IDLE and clear HI/LO; the partial result is discarded; Stall drops next cycle.
//  HI/LO change only on: MTHI/MTLO in IDLE, the final BUSY edge, or Reset.
//  No flush input. An instruction that reached EX always completes.
// TESTING
//  1) MULT rs=-3, rt=5 -> Stall high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; Done pulses once.
//  2) MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  3) DIV rs=7, rt=-2 -> LO=0xFFFFFFFD, HI=1. DIV rs=0x80000000, rt=-1 -> LO=0x80000000, HI=0.
//  4) DIVU rs=0x1234, rt=0 -> after 33 stall cycles: LO=0xFFFFFFFF, HI=0x1234.
//  5) MTHI 0xAAAA then MTLO 0x5555 back-to-back -> no Stall; HI=0xAAAA, LO=0x5555 one edge after each.
//  6) Reset at BUSY cycle 10 of a MULT -> next cycle state=IDLE, Stall=0, HI=LO=0. A following DIVU 9/2 -> LO=4, HI=1.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; stalls the front end while busy.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [2:0]       MDOp_EX,
    input  logic [WIDTH-1:0] rs_value_EX,
    input  logic [WIDTH-1:0] rt_value_EX,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] raw_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             negq_q;
    logic             negr_q;
    logic             dz_q;

    logic issue, start, last, mt_hi, mt_lo;

    assign issue = (MDOp_EX == OP_MULT) || (MDOp_EX == OP_MULTU) ||
                   (MDOp_EX == OP_DIV)  || (MDOp_EX == OP_DIVU);

    always_comb begin
        state_d = state_q;
        Stall   = 1'b0;
        Done    = 1'b0;
        start   = 1'b0;
        last    = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mt_hi = (MDOp_EX == OP_MTHI);
                mt_lo = (MDOp_EX == OP_MTLO);
                if (issue) begin
                    Stall   = 1'b1;
                    start   = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                Stall = 1'b1;
                if (cnt_q == CW'(1)) begin
                    last    = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand magnitudes and result signs captured at issue
    logic             sop, neg_a, neg_b, is_div;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign sop    = (MDOp_EX == OP_MULT) || (MDOp_EX == OP_DIV);
    assign is_div = (MDOp_EX == OP_DIV)  || (MDOp_EX == OP_DIVU);
    assign neg_a  = sop & rs_value_EX[WIDTH-1];
    assign neg_b  = sop & rt_value_EX[WIDTH-1];
    assign abs_a  = neg_a ? -rs_value_EX : rs_value_EX;
    assign abs_b  = neg_b ? -rt_value_EX : rt_value_EX;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

    assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], q_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;

    assign div_sh    = {acc_q, q_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_sh} - {2'b00, m_q};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_quo_n = {q_q[WIDTH-2:0], div_ok};

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign step_hi = div_q ? div_rem_n : mul_hi_n;
    assign step_lo = div_q ? div_quo_n : mul_lo_n;
    assign prod    = {mul_hi_n, mul_lo_n};
    assign prod_s  = negq_q ? -prod : prod;

    always_comb begin
        fin_hi = prod_s[2*WIDTH-1:WIDTH];
        fin_lo = prod_s[WIDTH-1:0];
        if (div_q) begin
            if (dz_q) begin
                fin_hi = raw_q;
                fin_lo = '1;
            end else begin
                fin_hi = negr_q ? -div_rem_n : div_rem_n;
                fin_lo = negq_q ? -div_quo_n : div_quo_n;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            raw_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                acc_q  <= '0;
                q_q    <= is_div ? abs_a : abs_b;
                m_q    <= is_div ? abs_b : abs_a;
                raw_q  <= rs_value_EX;
                cnt_q  <= CW'(WIDTH);
                div_q  <= is_div;
                negq_q <= neg_a ^ neg_b;
                negr_q <= neg_a;
                dz_q   <= is_div && (rt_value_EX == '0);
            end else if (state_q == S_BUSY) begin
                acc_q <= step_hi;
                q_q   <= step_lo;
                cnt_q <= cnt_q - CW'(1);
            end
            if (last) begin
                HI <= fin_hi;
                LO <= fin_lo;
            end
            if (mt_hi) HI <= rs_value_EX;
            if (mt_lo) LO <= rs_value_EX;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit.
// Directed cases plus randomized ops checked against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic [2:0]  MDOp_EX;
    logic [31:0] rs_value_EX;
    logic [31:0] rt_value_EX;
    logic        Stall;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int errs   = 0;
    int checks = 0;

    logic [31:0] mh = '0;
    logic [31:0] ml = '0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .MDOp_EX(MDOp_EX),
        .rs_value_EX(rs_value_EX),
        .rt_value_EX(rt_value_EX),
        .Stall(Stall),
        .Done(Done),
        .HI(HI),
        .LO(LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] h,
                                  inout logic [31:0] l);
        longint sp;
        logic [63:0] up;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                h = up[63:32];
                l = up[31:0];
            end
            3'd2: begin
                up = {32'b0, a} * {32'b0, b};
                h = up[63:32];
                l = up[31:0];
            end
            3'd3: begin
                if (b == 0) begin
                    l = '1;
                    h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 0;
                end else begin
                    l = $signed(a) / $signed(b);
                    h = $signed(a) % $signed(b);
                end
            end
            3'd4: begin
                if (b == 0) begin
                    l = '1;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string nm);
        logic [31:0] eh, el;
        int sc;
        bit hold_bad;
        eh = mh;
        el = ml;
        model(op, a, b, eh, el);
        @(negedge Clk);
        MDOp_EX = op;
        rs_value_EX = a;
        rt_value_EX = b;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errs++;
            $display("FAIL %s issue_stall: got %b want 1", nm, Stall);
        end
        sc = 1;
        hold_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Stall !== 1'b1) break;
            sc++;
            if (Done !== 1'b0 || HI !== mh || LO !== ml) hold_bad = 1;
        end
        checks++;
        if (sc != 33) begin
            errs++;
            $display("FAIL %s stall_cycles: got %0d want 33", nm, sc);
        end
        checks++;
        if (hold_bad) begin
            errs++;
            $display("FAIL %s busy_hold: got changed want HI=%h LO=%h held", nm, mh, ml);
        end
        checks++;
        if (Done !== 1'b1) begin
            errs++;
            $display("FAIL %s done: got %b want 1", nm, Done);
        end
        checks++;
        if (HI !== eh) begin
            errs++;
            $display("FAIL %s HI: got %h want %h", nm, HI, eh);
        end
        checks++;
        if (LO !== el) begin
            errs++;
            $display("FAIL %s LO: got %h want %h", nm, LO, el);
        end
        @(posedge Clk);
        #1;
        MDOp_EX = 3'd0;
        #1;
        checks++;
        if (Stall !== 1'b0 || Done !== 1'b0 || HI !== eh || LO !== el) begin
            errs++;
            $display("FAIL %s after_fin: got S=%b D=%b HI=%h LO=%h want 0 0 %h %h",
                     nm, Stall, Done, HI, LO, eh, el);
        end
        mh = eh;
        ml = el;
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input string nm);
        @(negedge Clk);
        MDOp_EX = op;
        rs_value_EX = a;
        rt_value_EX = $urandom;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errs++;
            $display("FAIL %s stall: got %b want 0", nm, Stall);
        end
        model(op, a, 32'd0, mh, ml);
        @(posedge Clk);
        #1;
        MDOp_EX = 3'd0;
        checks++;
        if (HI !== mh || LO !== ml) begin
            errs++;
            $display("FAIL %s regs: got HI=%h LO=%h want %h %h", nm, HI, LO, mh, ml);
        end
    endtask

    task automatic test_reset();
        @(negedge Clk);
        MDOp_EX = 3'd5;
        rs_value_EX = 32'h1234;
        @(negedge Clk);
        checks++;
        if (Stall !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errs++;
            $display("FAIL reset: got S=%b D=%b HI=%h LO=%h want 0 0 0 0",
                     Stall, Done, HI, LO);
        end
        MDOp_EX = 3'd0;
        Reset = 1'b0;
        mh = '0;
        ml = '0;
    endtask

    task automatic test_mult();
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin
            errs++;
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffff1", HI, LO);
        end
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checks++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            errs++;
            $display("FAIL multu_const: got %h_%h want fffffffe_00000001", HI, LO);
        end
    endtask

    task automatic test_div();
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
        checks++;
        if (LO !== 32'hFFFF_FFFD || HI !== 32'd1) begin
            errs++;
            $display("FAIL div_const: got LO=%h HI=%h want fffffffd 1", LO, HI);
        end
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_op(3'd4, 32'h1234, 32'd0, "divu_zero");
        checks++;
        if (LO !== 32'hFFFF_FFFF || HI !== 32'h1234) begin
            errs++;
            $display("FAIL divu_zero_const: got LO=%h HI=%h want ffffffff 1234", LO, HI);
        end
        run_op(3'd3, 32'hFFFF_FF00, 32'd0, "div_zero_neg");
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        MDOp_EX = 3'd5;
        rs_value_EX = 32'hAAAA;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errs++;
            $display("FAIL mthi_stall: got %b want 0", Stall);
        end
        @(negedge Clk);
        MDOp_EX = 3'd6;
        rs_value_EX = 32'h5555;
        #1;
        checks++;
        if (HI !== 32'hAAAA || Stall !== 1'b0) begin
            errs++;
            $display("FAIL mthi_b2b: got HI=%h S=%b want aaaa 0", HI, Stall);
        end
        @(negedge Clk);
        MDOp_EX = 3'd0;
        checks++;
        if (LO !== 32'h5555 || HI !== 32'hAAAA) begin
            errs++;
            $display("FAIL mtlo_b2b: got HI=%h LO=%h want aaaa 5555", HI, LO);
        end
        mh = 32'hAAAA;
        ml = 32'h5555;
    endtask

    task automatic test_reset_busy();
        @(negedge Clk);
        MDOp_EX = 3'd1;
        rs_value_EX = 32'hFFFF_FFFD;
        rt_value_EX = 32'd5;
        repeat (10) @(negedge Clk);
        Reset = 1'b1;
        MDOp_EX = 3'd0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errs++;
            $display("FAIL reset_busy: got S=%b D=%b HI=%h LO=%h want 0 0 0 0",
                     Stall, Done, HI, LO);
        end
        mh = '0;
        ml = '0;
        run_op(3'd4, 32'd9, 32'd2, "divu_9_2");
        checks++;
        if (LO !== 32'd4 || HI !== 32'd1) begin
            errs++;
            $display("FAIL divu_9_2_const: got LO=%h HI=%h want 4 1", LO, HI);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            if (op >= 3'd5) run_mt(op, a, "rand_mt");
            else run_op(op, a, b, "rand_op");
        end
    endtask

    initial begin
        Reset = 1'b1;
        MDOp_EX = 3'd0;
        rs_value_EX = '0;
        rt_value_EX = '0;
        repeat (2) @(posedge Clk);
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
